fp_sub_sequencer: RTL and testbench

FP_SUB_SEQUENCER -- requirements
Module: fp_sub_sequencer

---
 rtl/fp_sub_sequencer_if.sv | 32 +++
 rtl/fp_sub_sequencer.sv | 167 ++++++++++++++++
 tb/tb_fp_sub_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_sub_sequencer_if.sv
// Bus bundle for fp_sub_sequencer: point-pair input, shared float adder port, difference output.
// Every channel is valid/ready style: a transfer happens on a rising edge where valid/stb and ready/ack are both 1.
interface fp_sub_sequencer_if;
  logic        pt_valid;
  logic        pt_ready;
  logic [31:0] a1, a2, a3;
  logic [31:0] b1, b2, b3;
  logic [31:0] add_a, add_b;
  logic        add_a_stb, add_b_stb;
  logic        add_a_ack, add_b_ack;
  logic [31:0] add_z;
  logic        add_z_stb;
  logic        add_z_ack;
  logic [31:0] d1, d2, d3;
  logic        d_valid;
  logic        d_ready;
  logic        err;

  modport slave (
    input  pt_valid, a1, a2, a3, b1, b2, b3,
    input  add_a_ack, add_b_ack, add_z, add_z_stb, d_ready,
    output pt_ready, add_a, add_b, add_a_stb, add_b_stb, add_z_ack,
    output d1, d2, d3, d_valid, err
  );

  modport master (
    output pt_valid, a1, a2, a3, b1, b2, b3,
    output add_a_ack, add_b_ack, add_z, add_z_stb, d_ready,
    input  pt_ready, add_a, add_b, add_a_stb, add_b_stb, add_z_ack,
    input  d1, d2, d3, d_valid, err
  );
endinterface

// File: rtl/fp_sub_sequencer.sv
// Computes A-B per axis by time-sharing one external float adder (a_k + (-b_k)).
// Optional macro FP_SUB_SEQUENCER_ABS_DIFF_EN clears the sign of each stored difference.
module fp_sub_sequencer #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  fp_sub_sequencer_if.slave       bus,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_Z = 2'd2,
    OUT    = 2'd3
  } state_t;

  localparam int              CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [1:0]       axis_q, axis_d;
  logic [1:0]       axis_nxt;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [2:0][31:0] a_q, a_d;
  logic [2:0][31:0] b_q, b_d;
  logic [2:0][31:0] d_q, d_d;
  logic [31:0]      add_a_q, add_a_d;
  logic [31:0]      add_b_q, add_b_d;
  logic             a_stb_q, a_stb_d;
  logic             b_stb_q, b_stb_d;
  logic             pt_ready;
  logic             a_done, b_done;
  logic             z_take;
  logic             timeout;
  logic [31:0]      z_cap;

`ifdef FP_SUB_SEQUENCER_ABS_DIFF_EN
  assign z_cap = {1'b0, bus.add_z[30:0]};
`else
  assign z_cap = bus.add_z;
`endif

  assign pt_ready = (state_q == IDLE) && !err_q;
  assign axis_nxt = axis_q + 2'd1;
  // An operand is done once its strobe has already dropped or its ack is present now.
  assign a_done   = !a_stb_q || bus.add_a_ack;
  assign b_done   = !b_stb_q || bus.add_b_ack;
  assign z_take   = (state_q == WAIT_Z) && bus.add_z_stb;
  assign timeout  = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    axis_d  = axis_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    a_stb_d = a_stb_q;
    b_stb_d = b_stb_q;
    case (state_q)
      IDLE: begin
        if (bus.pt_valid && pt_ready) begin
          a_d     = {bus.a3, bus.a2, bus.a1};
          b_d     = {bus.b3, bus.b2, bus.b1};
          axis_d  = 2'd0;
          add_a_d = bus.a1;
          add_b_d = {~bus.b1[31], bus.b1[30:0]};
          a_stb_d = 1'b1;
          b_stb_d = 1'b1;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (a_stb_q && bus.add_a_ack) a_stb_d = 1'b0;
        if (b_stb_q && bus.add_b_ack) b_stb_d = 1'b0;
        if (a_done && b_done) begin
          cnt_d   = '0;
          state_d = WAIT_Z;
        end else if (timeout) begin
          err_d   = 1'b1;
          a_stb_d = 1'b0;
          b_stb_d = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_Z: begin
        if (bus.add_z_stb) begin
          d_d[axis_q] = z_cap;
          cnt_d       = '0;
          if (axis_q == 2'd2) begin
            state_d = OUT;
          end else begin
            axis_d  = axis_nxt;
            add_a_d = a_q[axis_nxt];
            add_b_d = {~b_q[axis_nxt][31], b_q[axis_nxt][30:0]};
            a_stb_d = 1'b1;
            b_stb_d = 1'b1;
            state_d = ISSUE;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUT: begin
        if (bus.d_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      axis_q  <= 2'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      a_stb_q <= 1'b0;
      b_stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      axis_q  <= axis_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      a_stb_q <= a_stb_d;
      b_stb_q <= b_stb_d;
    end
  end

  assign bus.pt_ready  = pt_ready;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_a_stb = a_stb_q;
  assign bus.add_b_stb = b_stb_q;
  // Result ack is combinational so it lasts exactly the one cycle the result is captured.
  assign bus.add_z_ack = z_take;
  assign bus.d1        = d_q[0];
  assign bus.d2        = d_q[1];
  assign bus.d3        = d_q[2];
  assign bus.d_valid   = (state_q == OUT);
  assign bus.err       = err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_fp_sub_sequencer.sv
// Directed bench for fp_sub_sequencer with a table-driven float-adder stand-in.
module tb_fp_sub_sequencer;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         n_tests;
  int         n_fail;

  fp_sub_sequencer_if bus ();

  fp_sub_sequencer #(.TIMEOUT_CYC(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

`ifdef FP_SUB_SEQUENCER_ABS_DIFF_EN
  localparam logic [31:0] D_MASK = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] D_MASK = 32'hFFFF_FFFF;
`endif

  typedef struct packed {
    logic [2:0][31:0] a;
    logic [2:0][31:0] b;
    logic [2:0][31:0] opb;
    logic [2:0][31:0] z;
    logic [3:0]       a_dly;
    logic [3:0]       b_dly;
    logic [3:0]       z_dly;
    logic [3:0]       hold;
  } vec_t;

  vec_t vecs [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.pt_valid  = 1'b0;
    bus.a1 = '0; bus.a2 = '0; bus.a3 = '0;
    bus.b1 = '0; bus.b2 = '0; bus.b3 = '0;
    bus.add_a_ack = 1'b0;
    bus.add_b_ack = 1'b0;
    bus.add_z     = '0;
    bus.add_z_stb = 1'b0;
    bus.d_ready   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pt_ready"}, bus.pt_ready, 1);
    chk({tag, "_a_stb"}, bus.add_a_stb, 0);
    chk({tag, "_b_stb"}, bus.add_b_stb, 0);
    chk({tag, "_z_ack"}, bus.add_z_ack, 0);
    chk({tag, "_add_a"}, bus.add_a, 0);
    chk({tag, "_add_b"}, bus.add_b, 0);
    chk({tag, "_d1"}, bus.d1, 0);
    chk({tag, "_d2"}, bus.d2, 0);
    chk({tag, "_d3"}, bus.d3, 0);
    chk({tag, "_d_valid"}, bus.d_valid, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  task automatic send_pair(input vec_t v);
    @(negedge clk);
    chk("pt_ready_before", bus.pt_ready, 1);
    bus.a1 = v.a[0]; bus.a2 = v.a[1]; bus.a3 = v.a[2];
    bus.b1 = v.b[0]; bus.b2 = v.b[1]; bus.b3 = v.b[2];
    bus.pt_valid = 1'b1;
    @(negedge clk);
    bus.pt_valid = 1'b0;
  endtask

  // Adder stand-in for one axis: checks operands and strobe timing, then returns z.
  task automatic adder_axis(input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] z,
                            input int ad, input int bd, input int zd, input bit do_z);
    int w;
    int last;
    w = 0;
    while (!(bus.add_a_stb && bus.add_b_stb) && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("stb_wait_bound", w < 40, 1);
    chk("add_a", bus.add_a, ea);
    chk("add_b", bus.add_b, eb);
    last = (ad > bd) ? ad : bd;
    for (int c = 0; c <= last + 1; c++) begin
      chk("a_stb_timing", bus.add_a_stb, c <= ad);
      chk("b_stb_timing", bus.add_b_stb, c <= bd);
      if (c <= ad) chk("add_a_hold", bus.add_a, ea);
      if (c <= bd) chk("add_b_hold", bus.add_b, eb);
      bus.add_a_ack = (c == ad);
      bus.add_b_ack = (c == bd);
      @(negedge clk);
    end
    bus.add_a_ack = 1'b0;
    bus.add_b_ack = 1'b0;
    if (do_z) begin
      for (int i = 0; i < zd; i++) begin
        chk("z_ack_idle", bus.add_z_ack, 0);
        @(negedge clk);
      end
      bus.add_z     = z;
      bus.add_z_stb = 1'b1;
      #1;
      chk("z_ack_high", bus.add_z_ack, 1);
      @(negedge clk);
      bus.add_z_stb = 1'b0;
      bus.add_z     = '0;
      #1;
      chk("z_ack_one_cycle", bus.add_z_ack, 0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] e1, e2, e3;
    e1 = v.z[0] & D_MASK;
    e2 = v.z[1] & D_MASK;
    e3 = v.z[2] & D_MASK;
    send_pair(v);
    for (int k = 0; k < 3; k++)
      adder_axis(v.a[k], v.opb[k], v.z[k], int'(v.a_dly), int'(v.b_dly), int'(v.z_dly), 1'b1);
    @(negedge clk);
    chk("d_valid_out", bus.d_valid, 1);
    chk("d1", bus.d1, e1);
    chk("d2", bus.d2, e2);
    chk("d3", bus.d3, e3);
    chk("pt_ready_out", bus.pt_ready, 0);
    for (int i = 0; i < int'(v.hold); i++) begin
      bus.pt_valid = (i == 2);
      bus.a1 = 32'h4120_0000;
      bus.b1 = 32'h4120_0000;
      @(negedge clk);
      chk("hold_d_valid", bus.d_valid, 1);
      chk("hold_d1", bus.d1, e1);
      chk("hold_d2", bus.d2, e2);
      chk("hold_d3", bus.d3, e3);
      chk("hold_pt_ready", bus.pt_ready, 0);
      chk("hold_a_stb", bus.add_a_stb, 0);
    end
    bus.pt_valid = 1'b0;
    bus.d_ready  = 1'b1;
    @(negedge clk);
    bus.d_ready = 1'b0;
    chk("d_valid_drop", bus.d_valid, 0);
    chk("pt_ready_back", bus.pt_ready, 1);
    chk("d1_kept", bus.d1, e1);
    @(negedge clk);
    chk("no_stray_issue", bus.add_a_stb, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    clear_inputs();

    // A=(3,5,-1) B=(1,7,-1)
    vecs[0].a     = {32'hBF80_0000, 32'h40A0_0000, 32'h4040_0000};
    vecs[0].b     = {32'hBF80_0000, 32'h40E0_0000, 32'h3F80_0000};
    vecs[0].opb   = {32'h3F80_0000, 32'hC0E0_0000, 32'hBF80_0000};
    vecs[0].z     = {32'h0000_0000, 32'hC000_0000, 32'h4000_0000};
    vecs[0].a_dly = 4'd0; vecs[0].b_dly = 4'd0; vecs[0].z_dly = 4'd0; vecs[0].hold = 4'd10;
    // A=(10,0.5,2) B=(4,0.25,8), b acked three cycles before a
    vecs[1].a     = {32'h4000_0000, 32'h3F00_0000, 32'h4120_0000};
    vecs[1].b     = {32'h4100_0000, 32'h3E80_0000, 32'h4080_0000};
    vecs[1].opb   = {32'hC100_0000, 32'hBE80_0000, 32'hC080_0000};
    vecs[1].z     = {32'hC0C0_0000, 32'h3E80_0000, 32'h40C0_0000};
    vecs[1].a_dly = 4'd3; vecs[1].b_dly = 4'd0; vecs[1].z_dly = 4'd2; vecs[1].hold = 4'd0;
    // A=(1.5,0,-3) B=(-2.5,0,1)
    vecs[2].a     = {32'hC040_0000, 32'h0000_0000, 32'h3FC0_0000};
    vecs[2].b     = {32'h3F80_0000, 32'h0000_0000, 32'hC020_0000};
    vecs[2].opb   = {32'hBF80_0000, 32'h8000_0000, 32'h4020_0000};
    vecs[2].z     = {32'hC080_0000, 32'h0000_0000, 32'h4080_0000};
    vecs[2].a_dly = 4'd1; vecs[2].b_dly = 4'd2; vecs[2].z_dly = 4'd4; vecs[2].hold = 4'd1;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    for (int i = 0; i < 3; i++) run_vec(vecs[i]);

    // Spurious adder result while idle
    bus.add_z     = 32'hDEAD_BEEF;
    bus.add_z_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("spurious_z_ack", bus.add_z_ack, 0);
      @(negedge clk);
    end
    bus.add_z_stb = 1'b0;
    bus.add_z     = '0;
    chk("spurious_d1", bus.d1, vecs[2].z[0] & D_MASK);
    chk("spurious_d2", bus.d2, vecs[2].z[1] & D_MASK);
    chk("spurious_d3", bus.d3, vecs[2].z[2] & D_MASK);

    // Reset during WAIT_Z of axis 1, then a full pair
    send_pair(vecs[0]);
    adder_axis(vecs[0].a[0], vecs[0].opb[0], vecs[0].z[0], 0, 0, 0, 1'b1);
    adder_axis(vecs[0].a[1], vecs[0].opb[1], vecs[0].z[1], 1, 0, 0, 1'b0);
    chk("pre_rst_state", state_dbg, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    run_vec(vecs[1]);

    // Adder never answers: timeout in WAIT_Z
    send_pair(vecs[0]);
    bus.add_a_ack = 1'b1;
    bus.add_b_ack = 1'b1;
    @(negedge clk);
    bus.add_a_ack = 1'b0;
    bus.add_b_ack = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      chk("err_before_timeout", bus.err, 0);
      @(negedge clk);
    end
    chk("err_set", bus.err, 1);
    chk("to_pt_ready", bus.pt_ready, 0);
    chk("to_a_stb", bus.add_a_stb, 0);
    chk("to_b_stb", bus.add_b_stb, 0);
    chk("to_z_ack", bus.add_z_ack, 0);
    chk("to_d_valid", bus.d_valid, 0);
    bus.pt_valid  = 1'b1;
    bus.add_z_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("err_z_ack", bus.add_z_ack, 0);
      @(negedge clk);
      chk("err_sticky", bus.err, 1);
      chk("err_no_accept", bus.add_a_stb, 0);
      chk("err_pt_ready", bus.pt_ready, 0);
    end
    bus.pt_valid  = 1'b0;
    bus.add_z_stb = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("err_cleared", bus.err, 0);
    chk("pt_ready_after_rst", bus.pt_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
